// File: rtl/branch_pkg.sv
// Shared opcode constants, branch condition encoding and BHT counter type
// for the execute-stage branch resolution logic.
package branch_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        BEQ  = 3'd0,
        BNE  = 3'd1,
        BLT  = 3'd4,
        BGE  = 3'd5,
        BLTU = 3'd6,
        BGEU = 3'd7
    } br_type_e;

    typedef logic [1:0] bht_cnt_t;

    localparam bht_cnt_t BHT_RESET = 2'b01;

    // 2-bit saturating step: up on taken, down on not-taken
    function automatic bht_cnt_t bht_train(input bht_cnt_t cnt, input logic taken);
        bht_cnt_t res;
        res = cnt;
        if (taken && cnt != 2'b11) begin
            res = cnt + 2'b01;
        end else if (!taken && cnt != 2'b00) begin
            res = cnt - 2'b01;
        end
        return res;
    endfunction

endpackage

// File: rtl/branch_bht.sv
// Bimodal table of 2-bit counters: one combinational read port and one
// training port; a read of the entry being trained sees the old value.
module branch_bht
    import branch_pkg::*;
#(
    parameter int ENTRIES = 16,
    localparam int IDX_W = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output bht_cnt_t         rd_cnt,
    input  logic             train_en,
    input  logic [IDX_W-1:0] train_idx,
    input  logic             train_taken
);

    bht_cnt_t cnt_reg [ENTRIES];

    // Counters live in flops: every entry must return to weak-NT on reset
    assign rd_cnt = cnt_reg[rd_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_reg[i] <= BHT_RESET;
            end
        end else if (train_en) begin
            cnt_reg[train_idx] <= bht_train(cnt_reg[train_idx], train_taken);
        end
    end

endmodule

// File: rtl/branch_predict_resolve.sv
// Execute-stage branch/jump resolution with mispredict detection, a
// saturating mispredict counter and a bimodal predictor for fetch.
module branch_predict_resolve
    import branch_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  fetch_pc,
    output logic             pred_taken,
    input  logic             ex_valid,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [6:0]       opcode,
    input  logic [2:0]       br_type,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    input  logic [XLEN-1:0]  imm,
    input  logic             ex_pred_taken,
    output logic             res_valid,
    output logic             br_taken,
    output logic [XLEN-1:0]  br_target,
    output logic             mispredict,
    output logic             illegal_br,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] ex_idx;
    bht_cnt_t         fetch_cnt;

    logic is_branch;
    logic is_jal;
    logic cond_taken;
    logic legal_type;

    logic res_valid_next;
    logic br_taken_next;
    logic mispredict_next;
    logic illegal_next;

    logic             res_valid_reg;
    logic             br_taken_reg;
    logic [XLEN-1:0]  br_target_reg;
    logic             mispredict_reg;
    logic             illegal_reg;
    logic [CNT_W-1:0] mispredict_cnt_reg;

    // Word-aligned PCs: bits [1:0] and the upper tag bits do not index
    assign fetch_idx = fetch_pc[IDX_W+1:2];
    assign ex_idx    = ex_pc[IDX_W+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc[XLEN-1:IDX_W+2], fetch_pc[1:0],
                              ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

    branch_bht #(
        .ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .clk         (clk),
        .reset       (reset),
        .rd_idx      (fetch_idx),
        .rd_cnt      (fetch_cnt),
        .train_en    (is_branch && legal_type),
        .train_idx   (ex_idx),
        .train_taken (cond_taken)
    );

    assign pred_taken = fetch_cnt[1];

    assign is_branch = ex_valid && (opcode == OPC_BRANCH);
    assign is_jal    = ex_valid && (opcode == OPC_JAL);

    always_comb begin
        cond_taken = 1'b0;
        legal_type = 1'b1;
        case (br_type)
            BEQ:     cond_taken = (rs1 == rs2);
            BNE:     cond_taken = (rs1 != rs2);
            BLT:     cond_taken = ($signed(rs1) <  $signed(rs2));
            BGE:     cond_taken = ($signed(rs1) >= $signed(rs2));
            BLTU:    cond_taken = (rs1 <  rs2);
            BGEU:    cond_taken = (rs1 >= rs2);
            default: legal_type = 1'b0;
        endcase
    end

    always_comb begin
        res_valid_next  = is_branch || is_jal;
        br_taken_next   = is_jal || (is_branch && legal_type && cond_taken);
        illegal_next    = is_branch && !legal_type;
        // Illegal types resolve not-taken, so they mispredict iff predicted taken
        mispredict_next = res_valid_next && (br_taken_next != ex_pred_taken);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res_valid_reg      <= 1'b0;
            br_taken_reg       <= 1'b0;
            br_target_reg      <= '0;
            mispredict_reg     <= 1'b0;
            illegal_reg        <= 1'b0;
            mispredict_cnt_reg <= '0;
        end else begin
            res_valid_reg  <= res_valid_next;
            br_taken_reg   <= br_taken_next;
            mispredict_reg <= mispredict_next;
            illegal_reg    <= illegal_next;
            if (res_valid_next) begin
                br_target_reg <= ex_pc + imm;
            end
            // Counter moves on the same edge that raises mispredict
            if (mispredict_next && !(&mispredict_cnt_reg)) begin
                mispredict_cnt_reg <= mispredict_cnt_reg + 1'b1;
            end
        end
    end

    assign res_valid      = res_valid_reg;
    assign br_taken       = br_taken_reg;
    assign br_target      = br_target_reg;
    assign mispredict     = mispredict_reg;
    assign illegal_br     = illegal_reg;
    assign mispredict_cnt = mispredict_cnt_reg;

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Directed and randomized bench for branch_predict_resolve, checked every
// cycle against a behavioural model of the resolution and predictor rules.
module tb_branch_predict_resolve;

    localparam int XLEN    = 32;
    localparam int ENTRIES = 16;
    localparam int CNT_W   = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [XLEN-1:0]  fetch_pc;
    logic             pred_taken;
    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc;
    logic [6:0]       opcode;
    logic [2:0]       br_type;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic [XLEN-1:0]  imm;
    logic             ex_pred_taken;
    logic             res_valid;
    logic             br_taken;
    logic [XLEN-1:0]  br_target;
    logic             mispredict;
    logic             illegal_br;
    logic [CNT_W-1:0] mispredict_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_predict_resolve #(
        .XLEN        (XLEN),
        .BHT_ENTRIES (ENTRIES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_pc       (fetch_pc),
        .pred_taken     (pred_taken),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .opcode         (opcode),
        .br_type        (br_type),
        .rs1            (rs1),
        .rs2            (rs2),
        .imm            (imm),
        .ex_pred_taken  (ex_pred_taken),
        .res_valid      (res_valid),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .mispredict     (mispredict),
        .illegal_br     (illegal_br),
        .mispredict_cnt (mispredict_cnt)
    );

    // ---------------- behavioural model ----------------
    int              tbl [ENTRIES];
    bit              model_on = 0;
    bit              m_valid, m_taken, m_mis, m_ill;
    logic [XLEN-1:0] m_tgt;
    int              m_cnt;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) tbl[i] = 1;
            m_valid = 0; m_taken = 0; m_mis = 0; m_ill = 0;
            m_tgt = '0; m_cnt = 0;
            model_on = 1;
        end else if (model_on) begin
            bit t, legal;
            int idx;
            idx = int'((ex_pc >> 2) % ENTRIES);
            t = 0;
            legal = 1;
            if (ex_valid && opcode == 7'h63) begin
                if (br_type == 0)      t = (rs1 == rs2);
                else if (br_type == 1) t = (rs1 != rs2);
                else if (br_type == 4) t = (signed'(rs1) < signed'(rs2));
                else if (br_type == 5) t = !(signed'(rs1) < signed'(rs2));
                else if (br_type == 6) t = (rs1 < rs2);
                else if (br_type == 7) t = !(rs1 < rs2);
                else legal = 0;
                m_valid = 1;
                m_taken = legal && t;
                m_ill = !legal;
                m_mis = (m_taken != ex_pred_taken);
                m_tgt = ex_pc + imm;
                if (legal) begin
                    if (t) tbl[idx] = (tbl[idx] == 3) ? 3 : tbl[idx] + 1;
                    else   tbl[idx] = (tbl[idx] == 0) ? 0 : tbl[idx] - 1;
                end
            end else if (ex_valid && opcode == 7'h6F) begin
                m_valid = 1; m_taken = 1; m_ill = 0;
                m_mis = !ex_pred_taken;
                m_tgt = ex_pc + imm;
            end else begin
                m_valid = 0; m_taken = 0; m_mis = 0; m_ill = 0;
            end
            if (m_mis && m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp, input bit quiet);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end else if (!quiet) begin
            $display("check %s ok value=%h", name, act);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        if (model_on && !reset) begin
            chk("res_valid",  32'(res_valid),  32'(m_valid), 1);
            chk("br_taken",   32'(br_taken),   32'(m_taken), 1);
            chk("mispredict", 32'(mispredict), 32'(m_mis),   1);
            chk("illegal_br", 32'(illegal_br), 32'(m_ill),   1);
            chk("br_target",  br_target,       m_tgt,        1);
            chk("mis_cnt",    32'(mispredict_cnt), 32'(m_cnt), 1);
            chk("pred_taken", 32'(pred_taken),
                32'(tbl[int'((fetch_pc >> 2) % ENTRIES)] >= 2), 1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [6:0] op, input logic [2:0] bt,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] im,
                        input logic pr);
        ex_valid = 1; opcode = op; br_type = bt;
        rs1 = a; rs2 = b; ex_pc = pc; imm = im; ex_pred_taken = pr;
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        ex_valid = 0; opcode = 7'h33;
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1; fetch_pc = '0; ex_valid = 0; ex_pc = '0; opcode = '0;
        br_type = '0; rs1 = '0; rs2 = '0; imm = '0; ex_pred_taken = 0;
        repeat (3) @(posedge clk);
        #2;
        reset = 0;
        fetch_pc = 32'h40;
        #1;
        chk("reset_pred",      32'(pred_taken),     32'h0, 0);
        chk("reset_res_valid", 32'(res_valid),      32'h0, 0);
        chk("reset_target",    br_target,           32'h0, 0);
        chk("reset_cnt",       32'(mispredict_cnt), 32'h0, 0);

        send(7'h63, 3'd4, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 0);
        chk("blt_taken",  32'(br_taken),       32'h1,   0);
        chk("blt_target", br_target,           32'h120, 0);
        chk("blt_mis",    32'(mispredict),     32'h1,   0);
        chk("blt_cnt",    32'(mispredict_cnt), 32'h1,   0);

        send(7'h63, 3'd6, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 0);
        chk("bltu_taken", 32'(br_taken),   32'h0, 0);
        chk("bltu_mis",   32'(mispredict), 32'h0, 0);

        fetch_pc = 32'h8;
        #1;
        chk("beq_pred0", 32'(pred_taken), 32'h0, 0);
        send(7'h63, 3'd0, 32'h5, 32'h5, 32'h8, 32'h4, 1);
        chk("beq_pred1", 32'(pred_taken), 32'h1, 0);
        send(7'h63, 3'd0, 32'h5, 32'h5, 32'h8, 32'h4, 1);
        chk("beq_pred2", 32'(pred_taken), 32'h1, 0);
        send(7'h63, 3'd0, 32'h5, 32'h5, 32'h8, 32'h4, 1);
        send(7'h63, 3'd0, 32'h5, 32'h5, 32'h8, 32'h4, 1);
        chk("beq_sat", 32'(pred_taken), 32'h1, 0);
        // From saturated 11: one not-taken stays predicted-taken, two drop it
        send(7'h63, 3'd1, 32'h5, 32'h5, 32'h8, 32'h4, 1);
        chk("nt1_pred", 32'(pred_taken), 32'h1, 0);

        send(7'h63, 3'd2, 32'h5, 32'h5, 32'h8, 32'h4, 1);
        chk("ill_flag",  32'(illegal_br), 32'h1, 0);
        chk("ill_taken", 32'(br_taken),   32'h0, 0);
        chk("ill_mis",   32'(mispredict), 32'h1, 0);
        chk("ill_pred",  32'(pred_taken), 32'h1, 0);

        send(7'h6F, 3'd0, 32'h0, 32'h0, 32'h8, 32'h40, 0);
        chk("jal_taken", 32'(br_taken),   32'h1, 0);
        chk("jal_mis",   32'(mispredict), 32'h1, 0);
        chk("jal_pred",  32'(pred_taken), 32'h1, 0);

        send(7'h63, 3'd1, 32'h5, 32'h5, 32'h8, 32'h4, 1);
        chk("nt2_pred", 32'(pred_taken), 32'h0, 0);

        send(7'h63, 3'd0, 32'h1, 32'h1, 32'hFFFF_FFF0, 32'h20, 1);
        chk("wrap_target", br_target, 32'h10, 0);
        idle();
        chk("idle_valid",  32'(res_valid), 32'h0,  0);
        chk("idle_target", br_target,      32'h10, 0);

        reset = 1;
        send(7'h63, 3'd0, 32'h5, 32'h5, 32'h8, 32'h4, 0);
        reset = 0;
        ex_valid = 0;
        #1;
        chk("rst_valid",  32'(res_valid),      32'h0, 0);
        chk("rst_taken",  32'(br_taken),       32'h0, 0);
        chk("rst_mis",    32'(mispredict),     32'h0, 0);
        chk("rst_target", br_target,           32'h0, 0);
        chk("rst_cnt",    32'(mispredict_cnt), 32'h0, 0);
        chk("rst_pred",   32'(pred_taken),     32'h0, 0);

        for (int n = 0; n < 3000; n++) begin
            logic [6:0] ops [3];
            ops[0] = 7'h63; ops[1] = 7'h6F; ops[2] = 7'h33;
            reset = ($urandom_range(0, 199) == 0);
            ex_valid = ($urandom_range(0, 9) != 0);
            opcode = ($urandom_range(0, 9) < 7) ? ops[0] : ops[$urandom_range(1, 2)];
            br_type = 3'($urandom_range(0, 7));
            rs1 = (n % 3 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            rs2 = ($urandom_range(0, 3) == 0) ? rs1 :
                  (n % 3 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            ex_pc = 32'($urandom_range(0, 31)) << 2;
            if ($urandom_range(0, 19) == 0) ex_pc = $urandom;
            imm = $urandom;
            ex_pred_taken = 1'($urandom_range(0, 1));
            fetch_pc = ($urandom_range(0, 1) == 0) ? ex_pc : 32'($urandom_range(0, 31)) << 2;
            @(posedge clk);
            #2;
        end
        reset = 0;
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predict_resolve.md
# branch_predict_resolve

Parametrised branch resolution unit with an integrated bimodal branch history table (BHT) for the RISC-V core pipeline. It sits at the execute stage. It resolves B-type conditional branches and J-type jumps from operand values, computes the target, and flags mispredictions against the fetch-time prediction. It trains a table of 2-bit saturating counters that the fetch stage reads through a combinational lookup port.

## Interface
- `XLEN`, default 32: operand, PC and immediate width.
- `BHT_ENTRIES`, default 16: number of counters; must be a power of two, at least 2.
- `CNT_W`, default 16: width of the saturating mispredict statistics counter.
- `clk`, in, 1: clock. One clock domain; all state updates on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `fetch_pc`, in, XLEN: PC being fetched.
- `pred_taken`, out, 1: combinational prediction, equal to the MSB of the counter indexed by `fetch_pc`.
- `ex_valid`, in, 1: execute-stage instruction valid.
- `ex_pc`, in, XLEN: PC of the executing instruction.
- `opcode`, in, 7: instruction opcode.
- `br_type`, in, 3: funct3 branch condition.
- `rs1`, `rs2`, in, XLEN: source operands.
- `imm`, in, XLEN: sign-extended offset.
- `ex_pred_taken`, in, 1: prediction carried down the pipe with this instruction.
- `res_valid`, out, 1: registered; resolution outputs are valid.
- `br_taken`, out, 1: registered resolved direction.
- `br_target`, out, XLEN: registered `ex_pc + imm`, modulo 2^XLEN.
- `mispredict`, out, 1: registered; resolved direction differs from `ex_pred_taken`.
- `illegal_br`, out, 1: registered; B-type with `br_type` of 2 or 3.
- `mispredict_cnt`, out, CNT_W: saturating count of mispredicts since reset.

## Operation
- The BHT index is `pc[$clog2(BHT_ENTRIES)+1:2]`. The same slice of `ex_pc` is used for training.
- Counter encoding is 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. All counters reset to 01.
- B-type (opcode 1100011): `br_type` selects the condition.
  - 0 BEQ, 1 BNE: equality.
  - 4 BLT, 5 BGE: signed compare.
  - 6 BLTU, 7 BGEU: unsigned compare.
  - 2 and 3: `br_taken`=0, `mispredict`=`ex_pred_taken`, `illegal_br`=1, and no BHT update.
  - For legal types, the indexed counter increments on taken and decrements on not-taken, saturating at 11 and 00.
- J-type (opcode 1101111): `br_taken`=1 and `mispredict`=`!ex_pred_taken`. No BHT update.
- Any other opcode, or `ex_valid`=0:
  - `res_valid`, `br_taken`, `mispredict` and `illegal_br` are 0 next cycle.
  - `br_target` holds its previous value.
  - No BHT or statistics update.
- `mispredict_cnt` increments each cycle the registered `mispredict` is set. It saturates at all-ones.

## Timing
- Resolution latency is 1 cycle: inputs sampled at edge N appear on the registered outputs after edge N, and the BHT update commits at edge N.
- `pred_taken` is combinational with zero latency.
- Same-cycle lookup and update to the same index returns the pre-update value (read-before-write).
- Back-to-back resolutions to one index each see the previous cycle's committed counter. Two taken resolutions from 01 give 10, then 11.
- Reset values: all registered outputs 0, `br_target` 0, `mispredict_cnt` 0, every counter 01.
- Reset asserted mid-stream has priority over any update in that cycle. No state from that cycle survives.
- There is no back-pressure: the unit accepts one instruction per cycle, every cycle.

## Structure
- Shared `branch_pkg` holds:
  - opcode constants `OPC_BRANCH` and `OPC_JAL`;
  - the `br_type_e` enum (BEQ, BNE, BLT, BGE, BLTU, BGEU);
  - the `bht_cnt_t` 2-bit type with `BHT_RESET` = 2'b01.
- One sub-module, `branch_bht`: the counter array with one read port, one write/train port, and the read-before-write rule.
- The compare, target and statistics logic live in the top module.

## Test plan
- Reset, then `fetch_pc`=0x40 → `pred_taken`=0. Every counter reads 01 and all outputs are 0.
- BLT with `rs1`=0xFFFFFFFF and `rs2`=1 (signed −1 < 1), `ex_pred_taken`=0, `ex_pc`=0x100, `imm`=0x20 → next cycle `br_taken`=1, `br_target`=0x120, `mispredict`=1, `mispredict_cnt`=1.
- The same operands with BLTU → `br_taken`=0 and `mispredict`=0.
- Three consecutive taken BEQ at `ex_pc`=0x8 while `fetch_pc`=0x8 → `pred_taken` reads 0, 1, 1 across the cycles. The counter ends saturated at 11 and a fourth taken BEQ leaves it at 11.
- `br_type`=2 with opcode 1100011 → `illegal_br`=1 and `br_taken`=0, with no counter change. JAL with `ex_pred_taken`=0 → `br_taken`=1 and `mispredict`=1, with no counter change.
- `ex_pc`=0xFFFFFFF0 with `imm`=0x20 → `br_target`=0x10 (wrap). Reset asserted in the same cycle as a taken branch → all outputs 0 and the counter stays 01.
